// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 sliding-window generator with two line buffers
//   clk, rst                 clock, asynchronous active-high reset
//   pix_in/pix_valid/pix_ready  raster-order pixel input handshake
//   a00..a22                 window, aRC = row R (0 = top), column C (0 = left)
//   win_valid/win_ready      window output handshake
//   frame_done               marks the last window of a frame
module window_gen_3x3 #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIDTH-1:0] a00,
  output logic [WIDTH-1:0] a01,
  output logic [WIDTH-1:0] a02,
  output logic [WIDTH-1:0] a10,
  output logic [WIDTH-1:0] a11,
  output logic [WIDTH-1:0] a12,
  output logic [WIDTH-1:0] a20,
  output logic [WIDTH-1:0] a21,
  output logic [WIDTH-1:0] a22,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0]    c_q, c_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] line0_q [IMG_W];
  logic [WIDTH-1:0] line1_q [IMG_W];
  logic [WIDTH-1:0] w_q [9];
  logic [WIDTH-1:0] w_d [9];
  logic             vld_q, vld_d, fd_q, fd_d;
  logic             acc, c_last, r_last;
  assign pix_ready = !vld_q || win_ready;
  assign acc       = pix_valid && pix_ready;
  assign c_last    = c_q == CW'(IMG_W - 1);
  assign r_last    = r_q == RW'(IMG_H - 1);
  // each row of the window shifts left; the right column is fed from
  // line1 (two rows up), line0 (one row up) and the incoming pixel
  always_comb begin
    w_d   = w_q;
    vld_d = vld_q;
    fd_d  = fd_q;
    c_d   = c_q;
    r_d   = r_q;
    if (acc) begin
      w_d[0] = w_q[1];
      w_d[1] = w_q[2];
      w_d[2] = line1_q[c_q];
      w_d[3] = w_q[4];
      w_d[4] = w_q[5];
      w_d[5] = line0_q[c_q];
      w_d[6] = w_q[7];
      w_d[7] = w_q[8];
      w_d[8] = pix_in;
      vld_d  = r_q >= RW'(2) && c_q >= CW'(2);
      fd_d   = r_last && c_last;
      c_d    = c_last ? '0 : c_q + 1'b1;
      r_d    = c_last ? (r_last ? '0 : r_q + 1'b1) : r_q;
    end else if (vld_q && win_ready) begin
      vld_d = 1'b0;
      fd_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
      c_q   <= '0;
      r_q   <= '0;
    end else begin
      w_q   <= w_d;
      vld_q <= vld_d;
      fd_q  <= fd_d;
      c_q   <= c_d;
      r_q   <= r_d;
    end
  end
  // line buffers are unreset: stale entries are only read for rows < 2,
  // whose windows are never marked valid
  always_ff @(posedge clk) begin
    if (acc) begin
      line1_q[c_q] <= line0_q[c_q];
      line0_q[c_q] <= pix_in;
    end
  end
  assign a00        = w_q[0];
  assign a01        = w_q[1];
  assign a02        = w_q[2];
  assign a10        = w_q[3];
  assign a11        = w_q[4];
  assign a12        = w_q[5];
  assign a20        = w_q[6];
  assign a21        = w_q[7];
  assign a22        = w_q[8];
  assign win_valid  = vld_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed self-checking bench for window_gen_3x3
module tb_window_gen_3x3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [8:0] pix_in = '0;
  logic       pix_valid = 1'b0, win_ready = 1'b1;
  logic       pix_ready, win_valid, frame_done;
  logic [8:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic [8:0] p3_in = '0;
  logic       p3_valid = 1'b0, r3 = 1'b1;
  logic       p3_ready, v3, fd3;
  logic [8:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
  window_gen_3x3 #(.WIDTH(9), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .a00(a00), .a01(a01), .a02(a02), .a10(a10), .a11(a11), .a12(a12),
    .a20(a20), .a21(a21), .a22(a22),
    .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
  );
  window_gen_3x3 #(.WIDTH(9), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .pix_in(p3_in), .pix_valid(p3_valid), .pix_ready(p3_ready),
    .a00(b00), .a01(b01), .a02(b02), .a10(b10), .a11(b11), .a12(b12),
    .a20(b20), .a21(b21), .a22(b22),
    .win_valid(v3), .win_ready(r3), .frame_done(fd3)
  );
  int checks = 0, errors = 0;
  logic [81:0] got_q [$];
  int   nwin = 0, stall_idx = -1, stall_left = 0;
  bit   rnd = 0, lat_en = 0, lat_ck = 0, held_ok = 0, dummy;
  logic [80:0] held;
  task automatic chk(input string tag, input logic [81:0] got, input logic [81:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [80:0] cur();
    return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
  endfunction
  task automatic step(input logic v, input logic [8:0] p, output bit acc);
    @(negedge clk);
    pix_valid = v;
    pix_in    = p;
    win_ready = 1'b1;
    if (win_valid && nwin == stall_idx && stall_left > 0) begin
      win_ready = 1'b0;
      stall_left--;
      if (!held_ok) begin
        held    = cur();
        held_ok = 1;
      end else chk("stall_hold", {1'b0, cur()}, {1'b0, held});
    end
    #1;
    if (!win_ready) chk("stall_pix_ready", 82'(pix_ready), 82'(0));
    if (lat_ck) begin
      chk("latency_valid", 82'(win_valid), 82'(1));
      lat_ck = 0;
    end
    if (win_valid && win_ready) begin
      got_q.push_back({frame_done, cur()});
      nwin++;
    end
    acc = pix_valid && pix_ready;
    if (acc && lat_en && p == 9'd10) begin
      chk("latency_pre", 82'(win_valid), 82'(0));
      lat_ck = 1;
    end
  endtask
  task automatic send(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bit a = 0;
      int t = 0;
      while (!a && t < 50) begin
        step(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 9'(base + i), a);
        t++;
      end
      if (!a) chk("accept_timeout", 82'(0), 82'(1));
    end
  endtask
  task automatic drain(input int n);
    repeat (n) step(1'b0, 9'd0, dummy);
  endtask
  task automatic start();
    got_q.delete();
    nwin = 0;
  endtask
  task automatic check_frames(input string tag, input int b0, input int b1, input int nf);
    int tl [4]  = '{0, 1, 4, 5};
    int off [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    chk({tag, "_count"}, 82'(got_q.size()), 82'(4 * nf));
    for (int f = 0; f < nf; f++)
      for (int w = 0; w < 4; w++)
        if (got_q.size() > 0) begin
          logic [81:0] e = got_q.pop_front();
          int b = (f == 0) ? b0 : b1;
          for (int k = 0; k < 9; k++)
            chk($sformatf("%s_f%0d_w%0d_a%0d", tag, f, w, k), 82'(e[k*9 +: 9]), 82'(b + tl[w] + off[k]));
          chk($sformatf("%s_f%0d_w%0d_fd", tag, f, w), 82'(e[81]), 82'(w == 3));
        end
  endtask
  initial begin
    #1;
    chk("rst_win", {1'b0, cur()}, 82'(0));
    chk("rst_valid", 82'(win_valid), 82'(0));
    chk("rst_fd", 82'(frame_done), 82'(0));
    chk("rst_pix_ready", 82'(pix_ready), 82'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start();
    lat_en = 1;
    send(0, 16);
    lat_en = 0;
    drain(3);
    check_frames("s1", 0, 0, 1);
    start();
    stall_idx  = 1;
    stall_left = 3;
    held_ok    = 0;
    send(0, 16);
    drain(3);
    stall_idx = -1;
    check_frames("s2", 0, 0, 1);
    start();
    send(0, 16);
    send(100, 16);
    drain(3);
    check_frames("s3", 0, 100, 2);
    start();
    rnd = 1;
    send(0, 16);
    rnd = 0;
    drain(3);
    check_frames("s4", 0, 0, 1);
    start();
    send(0, 10);
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("s5_rst_win", {1'b0, cur()}, 82'(0));
    chk("s5_rst_valid", 82'(win_valid), 82'(0));
    chk("s5_rst_fd", 82'(frame_done), 82'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start();
    send(0, 16);
    drain(3);
    check_frames("s5", 0, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      p3_valid = 1'b1;
      p3_in    = 9'(i);
      #1;
      chk("s6_pre_valid", 82'(v3), 82'(0));
    end
    @(negedge clk);
    p3_valid = 1'b0;
    #1;
    chk("s6_valid", 82'(v3), 82'(1));
    chk("s6_fd", 82'(fd3), 82'(1));
    chk("s6_win", {1'b0, b22, b21, b20, b12, b11, b10, b02, b01, b00},
        {1'b0, 9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1});
    @(negedge clk);
    #1;
    chk("s6_post_valid", 82'(v3), 82'(0));
    chk("s6_post_fd", 82'(fd3), 82'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
